// File: rtl/ultrasonic_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// ultrasonic_scheduler_pkg
// Shared definitions for the ultrasonic ranger scheduler:
//   - state_e      : scheduler FSM states
//   - DEF_*        : default timing constants for a 50 MHz clock
//   - cnt_width()  : bits needed by a counter that runs 0 .. n-1
// ---------------------------------------------------------------------------
package ultrasonic_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        HOLD      = 3'd4
    } state_e;

    // 50 MHz defaults: 10 us trigger, 58 us per cm, 60 ms period, 24 ms timeout
    localparam int unsigned DEF_TRIG_CYCLES    = 500;
    localparam int unsigned DEF_CM_CYCLES      = 2900;
    localparam int unsigned DEF_PERIOD_CYCLES  = 3000000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1200000;
    localparam int unsigned DEF_DIST_W         = 9;
    localparam int unsigned DEF_NEAR_CM        = 20;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/ultrasonic_scheduler_if.sv
// ---------------------------------------------------------------------------
// ultrasonic_scheduler_if
// Measurement result bus from the scheduler to distance consumers.
//   distance_o : last valid distance in cm (held between updates)
//   valid_o    : one-cycle strobe when distance_o updates
//   timeout_o  : one-cycle strobe when a measurement is aborted
//   near_o     : last valid distance <= near threshold
// Modports: master (scheduler drives), slave (consumer reads).
// ---------------------------------------------------------------------------
interface ultrasonic_scheduler_if
    import ultrasonic_scheduler_pkg::*;
#(
    parameter int unsigned DIST_W = DEF_DIST_W
) ();

    logic [DIST_W-1:0] distance_o;
    logic              valid_o;
    logic              timeout_o;
    logic              near_o;

    modport master (output distance_o, valid_o, timeout_o, near_o);
    modport slave  (input  distance_o, valid_o, timeout_o, near_o);

endinterface

// File: rtl/ultrasonic_scheduler_echo_sync_edge.sv
// ---------------------------------------------------------------------------
// ultrasonic_scheduler_echo_sync_edge
// Two-flop synchronizer for the asynchronous echo pin plus edge detection.
//   clk, rst : clock, asynchronous active-high reset
//   echo_i   : raw echo pin
//   level_o  : synchronized echo level (2 cycles behind the pin)
//   rise_o   : one-cycle strobe on a synchronized 0->1 transition
//   fall_o   : one-cycle strobe on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module ultrasonic_scheduler_echo_sync_edge
    import ultrasonic_scheduler_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic echo_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_scheduler.sv
// ---------------------------------------------------------------------------
// ultrasonic_scheduler
// Periodically triggers an HC-SR04-style ranger, times the echo pulse and
// reports the distance in centimetres, aborting on a missing/long echo.
//   clk, rst   : 50 MHz clock, asynchronous active-high reset
//   ready_i    : measurements are scheduled while high
//   echo_i     : raw asynchronous echo pin
//   trig_o     : trigger pulse to the sensor
//   busy_o     : scheduler is not IDLE
//   meas_o     : result bus (distance_o, valid_o, timeout_o, near_o)
// Optional build macro ULTRASONIC_AVG_EN: report the mean of the last four
// valid measurements instead of the raw one (valid_o one cycle later).
// ---------------------------------------------------------------------------
module ultrasonic_scheduler
    import ultrasonic_scheduler_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int unsigned CM_CYCLES      = DEF_CM_CYCLES,
    parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned DIST_W         = DEF_DIST_W,
    parameter int unsigned NEAR_CM        = DEF_NEAR_CM
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ready_i,
    input  logic                          echo_i,
    output logic                          trig_o,
    output logic                          busy_o,
    ultrasonic_scheduler_if.master        meas_o
);

    localparam int unsigned TRIG_W = cnt_width(TRIG_CYCLES);
    localparam int unsigned CM_W   = cnt_width(CM_CYCLES);
    localparam int unsigned PER_W  = cnt_width(PERIOD_CYCLES);
    localparam int unsigned TO_W   = cnt_width(TIMEOUT_CYCLES);

    localparam logic [TRIG_W-1:0] TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [CM_W-1:0]   CM_LAST   = CM_W'(CM_CYCLES - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DIST_W-1:0] DIST_MAX  = {DIST_W{1'b1}};

    // Saturating centimetre increment: long echoes pin at full scale.
    function automatic logic [DIST_W-1:0] cm_sat_inc(input logic [DIST_W-1:0] v);
        return (v == DIST_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic is_near(input logic [DIST_W-1:0] d);
        return (32'(d) <= NEAR_CM);
    endfunction

`ifdef ULTRASONIC_AVG_EN
    function automatic logic [DIST_W-1:0] avg4(input logic [DIST_W-1:0] a,
                                               input logic [DIST_W-1:0] b,
                                               input logic [DIST_W-1:0] c,
                                               input logic [DIST_W-1:0] d);
        logic [DIST_W+1:0] sum;
        sum = (DIST_W+2)'(a) + (DIST_W+2)'(b) + (DIST_W+2)'(c) + (DIST_W+2)'(d);
        return sum[DIST_W+1:2];
    endfunction
`endif

    logic echo_lvl;
    logic echo_rise;
    logic echo_fall;

    ultrasonic_scheduler_echo_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .echo_i  (echo_i),
        .level_o (echo_lvl),
        .rise_o  (echo_rise),
        .fall_o  (echo_fall)
    );

    state_e              state_q;
    logic [TRIG_W-1:0]   trig_cnt_q;
    logic [PER_W-1:0]    per_cnt_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic [CM_W-1:0]     sub_cnt_q;
    logic [DIST_W-1:0]   cm_cnt_q;
    logic                trig_q;
    logic [DIST_W-1:0]   dist_q;
    logic                valid_q;
    logic                timeout_q;
    logic                near_q;
`ifdef ULTRASONIC_AVG_EN
    logic [DIST_W-1:0]   hist_q [4];
    logic                avg_pend_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            trig_cnt_q <= '0;
            per_cnt_q  <= '0;
            to_cnt_q   <= '0;
            sub_cnt_q  <= '0;
            cm_cnt_q   <= '0;
            trig_q     <= 1'b0;
            dist_q     <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            near_q     <= 1'b0;
`ifdef ULTRASONIC_AVG_EN
            for (int i = 0; i < 4; i++) hist_q[i] <= '0;
            avg_pend_q <= 1'b0;
`endif
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;

            // Period counter runs from trigger start and saturates, so a
            // measurement longer than the period still cannot retrigger early.
            if (state_q != IDLE && per_cnt_q != PER_LAST)
                per_cnt_q <= per_cnt_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (ready_i) begin
                        state_q    <= TRIG;
                        trig_q     <= 1'b1;
                        trig_cnt_q <= '0;
                        per_cnt_q  <= '0;
                    end
                end

                TRIG: begin
                    if (trig_cnt_q == TRIG_LAST) begin
                        trig_q   <= 1'b0;
                        state_q  <= WAIT_ECHO;
                        to_cnt_q <= '0;
                    end else begin
                        trig_cnt_q <= trig_cnt_q + 1'b1;
                    end
                end

                // Only a rise seen here starts timing; an echo already high
                // on entry produces no rise strobe until it cycles again.
                WAIT_ECHO: begin
                    if (to_cnt_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= HOLD;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (echo_rise) begin
                            state_q <= MEASURE;
                            // The rise cycle is the first high cycle counted.
                            if (CM_CYCLES == 1) begin
                                sub_cnt_q <= '0;
                                cm_cnt_q  <= DIST_W'(1);
                            end else begin
                                sub_cnt_q <= CM_W'(1);
                                cm_cnt_q  <= '0;
                            end
                        end
                    end
                end

                // Echo fall is checked before timeout so it wins a tie.
                MEASURE: begin
                    if (echo_fall) begin
                        state_q <= HOLD;
`ifdef ULTRASONIC_AVG_EN
                        hist_q[0]  <= cm_cnt_q;
                        hist_q[1]  <= hist_q[0];
                        hist_q[2]  <= hist_q[1];
                        hist_q[3]  <= hist_q[2];
                        avg_pend_q <= 1'b1;
`else
                        dist_q  <= cm_cnt_q;
                        valid_q <= 1'b1;
                        near_q  <= is_near(cm_cnt_q);
`endif
                    end else if (to_cnt_q == TO_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= HOLD;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                        if (echo_lvl) begin
                            if (sub_cnt_q == CM_LAST) begin
                                sub_cnt_q <= '0;
                                cm_cnt_q  <= cm_sat_inc(cm_cnt_q);
                            end else begin
                                sub_cnt_q <= sub_cnt_q + 1'b1;
                            end
                        end
                    end
                end

                HOLD: begin
                    if (per_cnt_q == PER_LAST) begin
                        if (ready_i) begin
                            state_q    <= TRIG;
                            trig_q     <= 1'b1;
                            trig_cnt_q <= '0;
                            per_cnt_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    trig_q  <= 1'b0;
                end
            endcase

`ifdef ULTRASONIC_AVG_EN
            // Average is taken one cycle after the buffer shift.
            if (avg_pend_q) begin
                avg_pend_q <= 1'b0;
                dist_q     <= avg4(hist_q[0], hist_q[1], hist_q[2], hist_q[3]);
                near_q     <= is_near(avg4(hist_q[0], hist_q[1], hist_q[2], hist_q[3]));
                valid_q    <= 1'b1;
            end
`endif
        end
    end

    assign trig_o           = trig_q;
    assign busy_o           = (state_q != IDLE);
    assign meas_o.distance_o = dist_q;
    assign meas_o.valid_o    = valid_q;
    assign meas_o.timeout_o  = timeout_q;
    assign meas_o.near_o     = near_q;

endmodule

// File: doc/ultrasonic_scheduler.md
Name: ultrasonic_scheduler

Overview:
Sequences the HC-SR04-style ultrasonic ranger in the top-level sensor path.
- Issues periodic trigger pulses and times the returned echo.
- Converts echo width to centimetres, flags timeouts, and raises a "near" indication for the pet-interaction logic.
- Sits between the raw echo_i pin and the consumers of distance data, replacing ad-hoc free-running triggering.

Parameters:
TRIG_CYCLES, 500, trigger pulse width in clk cycles (10 us at 50 MHz)
CM_CYCLES, 2900, clk cycles of echo per centimetre (58 us at 50 MHz)
PERIOD_CYCLES, 3000000, minimum cycles between trigger rising edges (60 ms)
TIMEOUT_CYCLES, 1200000, max cycles from trigger end to echo fall before abort
DIST_W, 9, distance width in cm
NEAR_CM, 20, near_o threshold in cm (distance <= NEAR_CM)

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous, active-high reset
ready_i  input  1  enable; measurements are scheduled while high
echo_i  input  1  raw echo from sensor, asynchronous
trig_o  output  1  trigger pulse to sensor
busy_o  output  1  high in any state other than IDLE
distance_o  output  DIST_W  last valid distance in cm, held between updates
valid_o  output  1  one-cycle pulse when distance_o updates
timeout_o  output  1  one-cycle pulse on timeout abort
near_o  output  1  registered: last valid distance <= NEAR_CM

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, all counters 0.
- Reset mid-operation drops trig_o immediately.
- echo_i passes through a 2-flop synchronizer. All echo timing uses the synchronized signal, which adds 2 cycles of latency.
- State machine:
  - IDLE: when ready_i=1, go to TRIG next cycle and clear the period counter.
  - TRIG: trig_o=1 for exactly TRIG_CYCLES cycles, then WAIT_ECHO. Clear the timeout counter.
  - WAIT_ECHO: wait for a synchronized echo rising edge (0->1), then MEASURE. An echo already high on entry is ignored until it falls and rises again.
  - MEASURE: a sub-counter counts to CM_CYCLES-1, wraps, and increments a cm counter. So distance = floor(high_cycles / CM_CYCLES).
  - cm counter saturates at 2^DIST_W-1 (no wrap).
  - On echo falling edge: distance_o <= cm count, valid_o pulses the same cycle, near_o updates the same cycle, then HOLD.
  - Timeout: the timeout counter runs through WAIT_ECHO and MEASURE. On reaching TIMEOUT_CYCLES, timeout_o pulses and the block goes to HOLD. distance_o and near_o are unchanged.
  - Timeout and echo fall in the same cycle: the echo fall wins (valid_o, no timeout_o).
  - HOLD: wait until the period counter (started at TRIG entry) reaches PERIOD_CYCLES-1. Then go to TRIG if ready_i=1, else IDLE.
- ready_i deasserted mid-measurement: the current measurement completes normally, including HOLD, then IDLE.
- Trigger rising edges are never closer than PERIOD_CYCLES apart.

Optional Feature:
ULTRASONIC_AVG_EN
- Defined: valid measurements enter a 4-entry shift buffer.
  - distance_o = (sum of the 4 entries) >> 2. The sum is DIST_W+2 bits wide.
  - The buffer is zero at reset, so the first three outputs ramp up.
  - near_o compares against the averaged value.
  - valid_o is delayed 1 cycle relative to the echo fall.
- Undefined: raw single-shot distance, timing as above.
- Timeouts never enter the buffer.

Decomposition:
- Shared package holds:
  - state enum: IDLE, TRIG, WAIT_ECHO, MEASURE, HOLD
  - default timing constants for 50 MHz: trigger, cm, period, timeout
  - DIST_W
- One natural sub-module: echo_sync_edge, a 2-flop synchronizer producing level, rise and fall strobes.
- The averaging buffer stays inline under the macro.

Test Plan:
Sim parameters: TRIG_CYCLES=10, CM_CYCLES=100, PERIOD_CYCLES=5000, TIMEOUT_CYCLES=2000, NEAR_CM=20.
- Reset then ready_i=1 -> trig_o high exactly 10 cycles starting 1 cycle after reset release; busy_o=1.
- Echo high 1250 cycles after trigger -> distance_o=12, one valid_o pulse, near_o=1, next trig_o rise exactly 5000 cycles after the first.
- Echo high 2500 cycles -> timeout_o pulse at 2000 cycles after trigger end, no valid_o, distance_o keeps its previous value (12).
- Echo already high at WAIT_ECHO entry, falls, then rises for 300 cycles -> distance_o=3; the stale echo is ignored.
- ready_i dropped during MEASURE -> measurement reported, then IDLE after HOLD, no further trig_o. Async rst mid-TRIG -> trig_o=0 within the same cycle.
- With ULTRASONIC_AVG_EN defined and echoes of 400, 800, 1200, 1600 cycles -> distance_o sequence 1, 3, 6, 10.
